uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Byte-to-line UART transmitter that sits directly downstream of the frame generator. Accepts single-cycle `wrsig` byte strobes into a small FIFO, absorbing strobes that arrive while a byte is still on the wire, and serializes each byte LSB-first as start / 8 data / optional parity / stop bits on `tx`. Bit timing is derived from `clk` by a fixed per-bit cycle count.

## Interface

- `CLKS_PER_BIT`, default 16: clk cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, default 4: byte buffer depth; power of two, ≥ 2.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.

Ports:

- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  synchronous, active-high reset.
- `datain`  in  8  byte from the frame generator; sampled only when `wrsig` = 1.
- `wrsig`  in  1  one-cycle write strobe.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `ovf`  out  1  sticky flag: a strobe was dropped because the FIFO was full.

## Operation

- **Reset.** On the rising edge with `rst` = 1:
  - `tx` = 1, `busy` = 0, `ovf` = 0.
  - FIFO emptied, state = IDLE, bit timer = 0.
  - Reset mid-frame aborts the frame immediately; `tx` returns high on that edge.
- **Write.** On `wrsig` = 1 with the FIFO not full, `datain` is pushed.
  - If the FIFO is full, the byte is dropped and `ovf` is set.
  - Fullness is judged on the registered count. A push into a full FIFO is dropped even if a pop occurs on the same edge.
  - `wrsig` held high for k cycles is k pushes.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx` = 1. If the FIFO is non-empty, pop into the shift register, compute parity, go to START.
  - START: `tx` = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx` = shift[0] for CLKS_PER_BIT cycles per bit, 8 bits LSB first.
    - After bit 7, go to PARITY if PARITY ≠ 0, otherwise STOP.
  - PARITY: `tx` = parity bit for CLKS_PER_BIT cycles.
    - Odd: total number of ones over data plus parity is odd. Even: that total is even.
  - STOP: `tx` = 1 for STOP_BITS × CLKS_PER_BIT cycles.
    - At the end, if the FIFO is non-empty, pop and go straight to START, so back-to-back frames have no idle gap.
    - Otherwise go to IDLE.
- **`busy`** = (state ≠ IDLE) OR (FIFO count ≠ 0), registered.
- **Widths.**
  - Bit timer is clog2(CLKS_PER_BIT) bits and wraps at CLKS_PER_BIT−1.
  - FIFO count is clog2(FIFO_DEPTH)+1 bits.
  - FIFO pointers wrap modulo FIFO_DEPTH.
- **Input rules.** `datain` is ignored when `wrsig` = 0. A pop never occurs on an empty FIFO.

## Timing

- **Latency.** Strobe at edge E into an empty FIFO with the FSM in IDLE:
  - FIFO write at E, FSM pop at E+1.
  - `tx` falls at E+1, i.e. it is low in the cycle after E+1.
- **Frame length:** (1 + 8 + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles. Defaults give 160 cycles.
- **Bit boundaries:** every `tx` transition is registered and lands exactly CLKS_PER_BIT edges after the previous boundary. No glitches.
- **Rate compatibility:** the frame generator strobes every 255 cycles. With defaults (160 cycles/frame), or the worst case of 192 cycles with parity and 2 stop bits, the FIFO never exceeds 1 entry in steady state.
- **`ovf`** rises one edge after the dropped strobe. It clears only on `rst`.
- **`busy`** rises the edge after the first push and falls the edge after the final STOP period ends with the FIFO empty.

## Structure

- **Shared package `uart_pkg`:**
  - FSM state enumeration (IDLE/START/DATA/PARITY/STOP).
  - Parity encoding constants: PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2.
  - Frame-bit-count helper function.
  - The downstream receiver will reuse this package.
- **Sub-module `uart_tx_fifo`** (synchronous FIFO):
  - Parameters: depth and width 8.
  - Interface: push, pop, full, empty, count.
  - Owns the drop-on-full decision and the `ovf` flag.
- **Top level:** the FSM, bit timer, shift register and parity logic.

## Test plan

- **Single byte.** Defaults; `wrsig` pulse with `datain` = 0x50 ('P').
  - `tx` is low starting in the cycle after E+1.
  - Then 16-cycle bits 0,0,0,0,1,0,1,0, then a stop bit of 1.
  - Total 160 cycles; `busy` drops one edge after the stop bit.
- **Back-to-back.** Strobes for 0x0D and 0x0A 2 cycles apart.
  - Two frames with no idle gap between the stop bit of 0x0D and the start bit of 0x0A.
  - `ovf` stays 0.
- **Overflow.** Six consecutive-cycle strobes with 0x01..0x06, FIFO_DEPTH = 4, FSM idle.
  - The first pops at E+1, so 0x01..0x05 are accepted and 0x06 is dropped.
  - `ovf` = 1; the line carries 0x01..0x05 in order.
- **Parity.** PARITY = 1 with 0x31, then PARITY = 2 with 0x31 (three ones).
  - Odd parity: parity bit = 0.
  - Even parity: parity bit = 1.
  - Frame length is 176 cycles.
- **Stop bits.** STOP_BITS = 2, CLKS_PER_BIT = 4, byte 0xFF.
  - `tx` is low for 4 cycles, then high for 40 cycles.
  - The next start bit of a queued byte begins no earlier than cycle 44 from the first start.
- **Reset mid-frame.** Assert `rst` during DATA bit 3 of 0xA5 with a second byte queued.
  - `tx` = 1, `busy` = 0, FIFO empty on that edge.
  - After release, no frame is sent until a new strobe.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, parity encodings and frame sizing.
// The receiver side imports this package as well.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Snapshot of the transmitter sequencing, for checkers bound to the block.
    typedef struct packed {
        tx_state_t  state;
        logic [2:0] bit_idx;
        logic       stop_idx;
        logic       fifo_full;
    } tx_dbg_t;

    // Serial bits per frame: start + 8 data + optional parity + stop bits.
    function automatic int frame_bits(input int parity, input int stop_bits);
        return 9 + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO in front of the serializer. Drops writes when full
// (judged on the registered count) and latches the drop in a sticky ovf flag.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
            if (push && full) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// Byte-to-line UART transmitter: FIFO-buffered bytes go out LSB-first as
// start / 8 data / optional parity / stop bits, each CLKS_PER_BIT clocks long.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] datain,
    input  logic       wrsig,
    output logic       tx,
    output logic       busy,
    output logic       ovf
);

    localparam int             TW        = $clog2(CLKS_PER_BIT);
    localparam int             CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TW-1:0]  T_LAST    = TW'(CLKS_PER_BIT - 1);
    localparam logic           STOP_LAST = (STOP_BITS == 2);

    tx_state_t     state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          par_bit, par_n;
    logic          stop_idx, stop_idx_n;
    logic          tx_n;
    logic          bit_end;

    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    tx_dbg_t       dbg_unused;

    function automatic logic parity_of(input logic [7:0] d);
        return (PARITY == PAR_ODD) ? ~^d : ^d;
    endfunction

    // wrsig is a fire-and-forget strobe with no ready: every high cycle is one
    // write attempt, and an attempt against a full FIFO is dropped and flagged on ovf.
    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wrsig),
        .din   (datain),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .ovf   (ovf)
    );

    assign bit_end    = (timer == T_LAST);
    assign dbg_unused = '{state: state, bit_idx: bit_idx, stop_idx: stop_idx, fifo_full: fifo_full};

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        par_n      = par_bit;
        stop_idx_n = stop_idx;
        fifo_pop   = 1'b0;

        if (state != ST_IDLE) begin
            timer_n = bit_end ? '0 : timer + 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_n  = fifo_dout;
                    par_n    = parity_of(fifo_dout);
                    timer_n  = '0;
                    state_n  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_idx_n = '0;
                    state_n   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_n    = {1'b0, shift[7:1]};
                    bit_idx_n  = bit_idx + 1'b1;
                    stop_idx_n = 1'b0;
                    if (bit_idx == 3'd7) begin
                        state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    stop_idx_n = 1'b0;
                    state_n    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_idx != STOP_LAST) begin
                        stop_idx_n = stop_idx + 1'b1;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next start bit: no idle gap.
                        fifo_pop = 1'b1;
                        shift_n  = fifo_dout;
                        par_n    = parity_of(fifo_dout);
                        state_n  = ST_START;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Line level is decoded from the next state so tx itself is a flop.
        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = shift_n[0];
            ST_PARITY: tx_n = par_n;
            default:   tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            stop_idx <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            par_bit  <= par_n;
            stop_idx <= stop_idx_n;
            tx       <= tx_n;
            busy     <= (state != ST_IDLE) || (fifo_count != '0);
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four parameterisations driven with directed bytes;
// per-instance line decoders pop expected {parity, byte} entries and compare.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rst_v;
    logic [3:0] wr_v;
    logic [7:0] din_v [4];
    wire  [3:0] tx_v;
    wire  [3:0] busy_v;
    wire  [3:0] ovf_v;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];
    logic [8:0] exp_q2[$];
    logic [8:0] exp_q3[$];

    int frames_seen [4] = '{default: 0};
    int last_start  [4] = '{default: 0};
    int prev_start  [4] = '{default: 0};

    uart_tx_serializer u_def (
        .clk(clk), .rst(rst_v[0]), .datain(din_v[0]), .wrsig(wr_v[0]),
        .tx(tx_v[0]), .busy(busy_v[0]), .ovf(ovf_v[0]));

    uart_tx_serializer #(.PARITY(1)) u_odd (
        .clk(clk), .rst(rst_v[1]), .datain(din_v[1]), .wrsig(wr_v[1]),
        .tx(tx_v[1]), .busy(busy_v[1]), .ovf(ovf_v[1]));

    uart_tx_serializer #(.PARITY(2)) u_even (
        .clk(clk), .rst(rst_v[2]), .datain(din_v[2]), .wrsig(wr_v[2]),
        .tx(tx_v[2]), .busy(busy_v[2]), .ovf(ovf_v[2]));

    uart_tx_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .rst(rst_v[3]), .datain(din_v[3]), .wrsig(wr_v[3]),
        .tx(tx_v[3]), .busy(busy_v[3]), .ovf(ovf_v[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    endtask

    function automatic void exp_push(input int id, input logic [8:0] v);
        case (id)
            0: exp_q0.push_back(v);
            1: exp_q1.push_back(v);
            2: exp_q2.push_back(v);
            default: exp_q3.push_back(v);
        endcase
    endfunction

    function automatic int exp_size(input int id);
        case (id)
            0: return exp_q0.size();
            1: return exp_q1.size();
            2: return exp_q2.size();
            default: return exp_q3.size();
        endcase
    endfunction

    function automatic logic [8:0] exp_pop(input int id);
        case (id)
            0: return exp_q0.pop_front();
            1: return exp_q1.pop_front();
            2: return exp_q2.pop_front();
            default: return exp_q3.pop_front();
        endcase
    endfunction

    // Line decoder: finds a start bit, samples every bit mid-period, compares.
    task automatic mon(input int id, input int cpb, input int par, input int sb);
        int          nb;
        int          idx;
        bit          ab;
        logic [11:0] fr;
        logic [8:0]  e;
        nb = 9 + ((par != 0) ? 1 : 0) + sb;
        forever begin
            @(negedge clk);
            if (rst_v[id] !== 1'b0 || tx_v[id] !== 1'b0) continue;
            prev_start[id] = last_start[id];
            last_start[id] = cyc;
            idx = 0;
            ab  = 1'b0;
            fr  = '0;
            for (int j = 0; j < nb && !ab; j++) begin
                while (idx < j * cpb + cpb / 2 && !ab) begin
                    @(negedge clk);
                    idx++;
                    if (rst_v[id] !== 1'b0) ab = 1'b1;
                end
                if (!ab) fr[j] = tx_v[id];
            end
            if (ab) continue;
            frames_seen[id]++;
            check($sformatf("frame_expected_i%0d", id), (exp_size(id) != 0), 1);
            if (exp_size(id) != 0) begin
                e = exp_pop(id);
                check($sformatf("start_bit_i%0d", id), fr[0], 1'b0);
                check($sformatf("data_i%0d", id), fr[8:1], e[7:0]);
                if (par != 0) check($sformatf("parity_i%0d", id), fr[9], e[8]);
                for (int k = nb - sb; k < nb; k++)
                    check($sformatf("stop_bit_i%0d", id), fr[k], 1'b1);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int id, input logic [7:0] d);
        din_v[id] = d;
        wr_v[id]  = 1'b1;
        tick();
        wr_v[id]  = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_frames(input int id, input int n, input int budget);
        int t;
        t = 0;
        while (frames_seen[id] < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("frame_count_i%0d", id), frames_seen[id], n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int fb;
        rst_v = 4'hF;
        wr_v  = 4'h0;
        for (int i = 0; i < 4; i++) din_v[i] = 8'h00;
        fork
            mon(0, 16, 0, 1);
            mon(1, 16, 1, 1);
            mon(2, 16, 2, 1);
            mon(3, 4, 0, 2);
        join_none

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check("reset_tx", tx_v, 4'hF);
        check("reset_busy", busy_v, 4'h0);
        check("reset_ovf", ovf_v, 4'h0);
        tick();
        rst_v = 4'h0;
        tick();

        // Single byte 'P': tx low after E+1, 160-cycle frame, busy falls at E+162
        exp_push(0, {1'b0, 8'h50});
        strobe(0, 8'h50);
        e = cyc;
        @(negedge clk);
        check("busy_before_pop", busy_v[0], 1'b0);
        @(negedge clk);
        check("busy_rise", busy_v[0], 1'b1);
        check("tx_start_low", tx_v[0], 1'b0);
        wait_cyc(e + 161);
        check("busy_last_stop", busy_v[0], 1'b1);
        check("tx_stop_high", tx_v[0], 1'b1);
        @(negedge clk);
        check("busy_fall", busy_v[0], 1'b0);
        wait_frames(0, 1, 400);
        check("start_latency", last_start[0] - e, 1);

        // Back-to-back: 0x0D then 0x0A two cycles later, no gap
        exp_push(0, {1'b0, 8'h0D});
        exp_push(0, {1'b0, 8'h0A});
        strobe(0, 8'h0D);
        tick();
        strobe(0, 8'h0A);
        wait_frames(0, 3, 600);
        check("b2b_start_spacing", last_start[0] - prev_start[0], 160);
        check("b2b_ovf", ovf_v[0], 1'b0);
        repeat (40) @(negedge clk);
        check("b2b_idle", busy_v[0], 1'b0);

        // Overflow: six strobes into depth 4, first popped at E+1, 0x06 dropped
        for (int i = 1; i <= 5; i++) exp_push(0, {1'b0, 8'(i)});
        for (int i = 1; i <= 6; i++) begin
            din_v[0] = 8'(i);
            wr_v[0]  = 1'b1;
            if (i == 6) begin
                @(negedge clk);
                check("ovf_before_drop", ovf_v[0], 1'b0);
            end
            tick();
        end
        wr_v[0] = 1'b0;
        @(negedge clk);
        check("ovf_set", ovf_v[0], 1'b1);
        wait_frames(0, 8, 1000);
        repeat (300) @(negedge clk);
        check("ovf_no_extra_frame", frames_seen[0], 8);
        check("ovf_queue_drained", exp_size(0), 0);
        check("ovf_sticky", ovf_v[0], 1'b1);

        // Parity: 0x31 has three ones -> odd parity bit 0, even parity bit 1; 176 cycles
        exp_push(1, {1'b0, 8'h31});
        exp_push(2, {1'b1, 8'h31});
        din_v[1] = 8'h31;
        din_v[2] = 8'h31;
        wr_v[1]  = 1'b1;
        wr_v[2]  = 1'b1;
        tick();
        wr_v[1]  = 1'b0;
        wr_v[2]  = 1'b0;
        e = cyc;
        wait_cyc(e + 177);
        check("parity_busy_last", busy_v[2:1], 2'b11);
        @(negedge clk);
        check("parity_busy_fall", busy_v[2:1], 2'b00);
        wait_frames(1, 1, 100);
        wait_frames(2, 1, 100);

        // Two stop bits at 4 clocks/bit: 0xFF then 0x00 queued
        exp_push(3, {1'b0, 8'hFF});
        exp_push(3, {1'b0, 8'h00});
        strobe(3, 8'hFF);
        e = cyc;
        strobe(3, 8'h00);
        wait_cyc(e + 4);
        check("stop2_start_low_end", tx_v[3], 1'b0);
        @(negedge clk);
        check("stop2_data_high", tx_v[3], 1'b1);
        wait_cyc(e + 44);
        check("stop2_last_stop_high", tx_v[3], 1'b1);
        wait_frames(3, 2, 200);
        check("stop2_start_spacing", last_start[3] - prev_start[3], 44);

        // Reset during data bit 3 of 0xA5 with 0x3C queued
        exp_push(0, {1'b0, 8'hA5});
        exp_push(0, {1'b0, 8'h3C});
        strobe(0, 8'hA5);
        e = cyc;
        strobe(0, 8'h3C);
        wait_cyc(e + 70);
        rst_v[0] = 1'b1;
        tick();
        @(negedge clk);
        check("rst_mid_tx", tx_v[0], 1'b1);
        check("rst_mid_busy", busy_v[0], 1'b0);
        check("rst_mid_ovf", ovf_v[0], 1'b0);
        tick();
        rst_v[0] = 1'b0;
        exp_q0.delete();
        fb = frames_seen[0];
        repeat (400) @(negedge clk);
        check("rst_no_frame", frames_seen[0], fb);
        check("rst_idle_busy", busy_v[0], 1'b0);
        exp_push(0, {1'b0, 8'h5A});
        strobe(0, 8'h5A);
        wait_frames(0, fb + 1, 400);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
